// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational integer ALU between two cores,
// with a per-core registered response slot under valid/ready and a contention counter.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [OP_W-1:0] OP_MAX = OP_W'(9);

    logic elig0, elig1;
    logic grant0, grant1;
    logic rr_last;
    logic illegal_op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A slot is eligible when it is empty or being drained on this same edge.
    assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

    // rr_last == 1 means requester 1 won most recently, so requester 0 has priority.
    assign grant0 = elig0 & (~elig1 | rr_last);
    assign grant1 = elig1 & (~elig0 | ~rr_last);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_control   = '0;
        if (grant0) begin
            alu_operand_a = req0_a;
            alu_operand_b = req0_b;
            alu_control   = req0_op;
        end else if (grant1) begin
            alu_operand_a = req1_a;
            alu_operand_b = req1_b;
            alu_control   = req1_op;
        end
    end

    assign illegal_op = (alu_control > OP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (grant0) begin
            rr_last <= 1'b0;
        end else if (grant1) begin
            rr_last <= 1'b1;
        end
    end

    // Response slot 0: reload on grant, otherwise clear once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp0_err    <= 1'b0;
        end else if (grant0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= illegal_op ? '0 : alu_result;
            rsp0_zero   <= illegal_op ? 1'b1 : alu_zero;
            rsp0_err    <= illegal_op;
        end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    // Response slot 1: same policy as slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
            rsp1_err    <= 1'b0;
        end else if (grant1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= illegal_op ? '0 : alu_result;
            rsp1_zero   <= illegal_op ? 1'b1 : alu_zero;
            rsp1_err    <= illegal_op;
        end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (elig0 & elig1) begin
            conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit integer ALU between the two cores' execute stages (requester 0 = core0, requester 1 = core1).
- Arbitrates requests round-robin and drives the ALU's operand/control inputs from the winner.
- Captures the ALU's combinational result/zero into a per-requester response register, held under a valid/ready handshake until the owning core accepts it.
- Counts contention cycles for performance monitoring.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU width.
- OP_W, 4, ALU control code width.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request presented by core0 / core1.
- req0_ready / req1_ready  out  1  request accepted this cycle (grant).
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- req0_op / req1_op  in  OP_W  ALU control code.
- rsp0_valid / rsp1_valid  out  1  response register holds a result.
- rsp0_ready / rsp1_ready  in  1  core consumes the response.
- rsp0_result / rsp1_result  out  DATA_W  registered ALU result.
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag.
- rsp0_err / rsp1_err  out  1  op code was illegal (greater than 4'b1001).
- alu_operand_a, alu_operand_b  out  DATA_W  to ALU.
- alu_control  out  OP_W  to ALU.
- alu_result  in  DATA_W  from ALU (combinational).
- alu_zero  in  1  from ALU.
- conflict_cnt  out  CNT_W  cycles in which both requesters were eligible.

Behaviour:
- Reset (asynchronous, rst_n low) clears:
  - all rsp*_valid, rsp*_result, rsp*_zero and rsp*_err to 0;
  - conflict_cnt to 0;
  - rr_last to 1, so requester 0 wins the first conflict.
- Reset takes effect mid-operation: a pending response is discarded.
- Eligibility:
  - elig_i = reqi_valid & (!rspi_valid | rspi_ready).
  - The response slot must be empty, or drained in the same cycle.
- Grant (combinational, at most one per cycle):
  - only one requester eligible: it is granted;
  - both eligible: grant the requester != rr_last;
  - neither eligible: no grant.
  - reqi_ready = grant_i.
  - reqi_ready never asserts without reqi_valid.
- rr_last updates to the granted index on each grant edge. It is unchanged when there is no grant.
- ALU drive:
  - while granted, alu_operand_a/b and alu_control equal the winner's req fields in the same cycle;
  - with no grant, drive all zeros (control 4'b0000).
- Capture on the grant edge into the winner's slot:
  - result <= alu_result, zero <= alu_zero, err <= 0, valid <= 1.
  - Illegal op (op > 4'b1001): result <= 0, zero <= 1, err <= 1, valid <= 1. The ALU is still driven.
- Latency: request accepted at edge N gives rspi_valid high from just after edge N. That is a 1-cycle accept-to-response latency with no bubbles.
- Response hold:
  - rspi_valid, result, zero and err stay stable until the edge where rspi_ready is high, then valid clears;
  - if a new grant to the same requester happens on that same edge, the slot is reloaded and valid stays 1.
- Throughput:
  - each requester can sustain 1 op/cycle alone when it drains every cycle;
  - under continuous contention the grants alternate 0,1,0,1.
- No starvation: a requester that stays eligible is granted within 2 cycles.
- conflict_cnt increments by 1 on each edge where elig0 & elig1, and saturates at all-ones.
- Requester inputs need not be held stable before grant. The arbiter samples them only on the grant edge.
- rspi_ready while rspi_valid = 0 has no effect.

Test Plan:
- Reset and single op:
  - stimulus: reset, then core0 ADD a=5, b=7 with rsp0_ready=1;
  - response: req0_ready=1 in the same cycle, next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0;
  - response: all outputs 0 during reset.
- Contention:
  - stimulus: both cores valid for 4 cycles; core0 SUB 9-9, core1 OR 0xF0|0x0F; both always ready;
  - response: grants 0,1,0,1;
  - response: core0 result 0 with zero=1; core1 result 0xFF;
  - response: conflict_cnt=4.
- Backpressure:
  - stimulus: core1 SLL 1<<4 with rsp1_ready=0 for 3 cycles, req1_valid held;
  - response: rsp1_result=16 held stable;
  - response: req1_ready=0 until the drain cycle, then grant and drain on the same edge keeps rsp1_valid=1.
- Illegal op:
  - stimulus: core0 op=4'b1100;
  - response: rsp0_err=1, rsp0_result=0, rsp0_zero=1.
- Asynchronous reset:
  - stimulus: drop rst_n between edges while rsp0_valid=1;
  - response: rsp0_valid=0 immediately, conflict_cnt=0;
  - response: the first conflict after release goes to requester 0.
- Saturation:
  - stimulus: force 2^CNT_W+3 contention cycles (CNT_W=4 build);
  - response: conflict_cnt sticks at 4'hF.
